ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 t1  input  1  timing pulse (one clk wide): latch instruction.
REQ-004 t2  input  1  timing pulse (one clk wide): execute/write-back.
REQ-005 ir  input  16  instruction word from fetch; valid when t1 is high.
REQ-006 pc  input  16  fetch PC (already incremented by 2); valid when t1 is high.
REQ-007 rsel  input  3  debug register-read select.
REQ-008 rdata  output  16  combinational read of R[rsel].
REQ-009 jp  output  1  branch taken; consumed by fetch at t3.
REQ-010 pcnew  output  16  branch target; consumed by fetch at t3.
REQ-011 zf, cf  output  1 each  zero / carry flags.
REQ-012 ill  output  1  sticky illegal-opcode flag.
REQ-013 busy  output  1  high while in S_EXE.

Function
REQ-014 Encoding SHALL be op=ir[15:12], rd=ir[11:9], rs=ir[8:6], imm8=ir[7:0], off12=ir[11:0].
REQ-015 State machine SHALL be S_IDLE, S_EXE, S_DONE; t1 from any state -> S_EXE; t2 in S_EXE -> S_DONE; t2 in S_IDLE/S_DONE ignored.
REQ-016 On t1 edge: latch ir and pc into internal copies, clear jp to 0; pcnew holds.
REQ-017 On t2 edge in S_EXE: perform operation on latched ir, update register file/flags/jp/pcnew; results visible the cycle after the t2 edge and stable until next t1.
REQ-018 t1 and t2 high in same cycle: t1 SHALL win, t2 ignored.
REQ-019 Register file SHALL be 8 x 16 bits, R0..R7, all writable.
REQ-020 op 0000 NOP: no state change.
REQ-021 op 0001 ADD: R[rd]=R[rd]+R[rs] mod 2^16; cf=carry out of bit 15.
REQ-022 op 0010 SUB: R[rd]=R[rd]-R[rs] mod 2^16; cf=1 iff R[rd]<R[rs] unsigned (borrow).
REQ-023 op 0011 AND, 0100 OR, 0101 XOR: bitwise R[rd] op R[rs] into R[rd]; cf=0.
REQ-024 op 0110 SHL: R[rd]=R[rd]<<1, cf=old bit 15; op 0111 SHR (logical): R[rd]=R[rd]>>1, cf=old bit 0.
REQ-025 For ops 0001-0111, zf=1 iff 16-bit result is 0x0000.
REQ-026 op 1000 MOVI: R[rd]={8'h00,imm8}; flags unchanged.
REQ-027 op 1001 JMP: jp=1, pcnew=pc_latched + (sign-extended off12 << 1), mod 2^16.
REQ-028 op 1010 BZ / 1011 BC: if zf / cf is 1, as JMP; otherwise jp=0, pcnew unchanged.
REQ-029 ops 1100-1111: treated as NOP, and ill SHALL set to 1 and stay 1 until rst.
REQ-030 For RD==RS, the operand SHALL be the pre-write value of that register.
REQ-031 busy SHALL equal (state==S_EXE).

Reset
REQ-032 rst SHALL dominate t1/t2 in the same cycle.
REQ-033 After rst: state=S_IDLE, R0..R7=0x0000, jp=0, pcnew=0x0000, zf=0, cf=0, ill=0, busy=0, latched ir=0x0000 (NOP), latched pc=0x0000.
REQ-034 rst between t1 and t2 SHALL abort the instruction: the subsequent t2 is ignored and no register or flag is written.

Verification
REQ-035 Reset: pulse rst with garbage register contents -> every rsel reads 0x0000; jp=0, pcnew=0, zf=cf=ill=busy=0.
REQ-036 MOVI: ir=0x827F (MOVI R1,0x7F), t1 then t2 -> rdata(rsel=1)=0x007F one cycle after t2; zf and cf unchanged.
REQ-037 ADD wrap: R1=0xFFFF, R2=0x0001, ir=0x1280 (ADD R1,R2) -> R1=0x0000, zf=1, cf=1; SUB R2,R1 (ir=0x2440) -> R2=0x0001, cf=0, zf=0.
REQ-038 Branch: zf=1, pc=0x0010, ir=0xA003 -> jp=1, pcnew=0x0016; zf=0 -> jp=0, pcnew held; JMP with off12=0xFFF -> pcnew=pc-2.
REQ-039 Timing edge cases: t2 with no prior t1 -> no change; t1 and t2 in the same cycle -> latch only, busy=1; rst between t1 and t2 -> no write.
REQ-040 Illegal: ir=0xF000 -> ill=1, registers unchanged; ill stays 1 across later legal instructions and clears only on rst.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: latches an instruction on t1, executes it on t2 against an
// 8x16 register file, and drives branch, flag and illegal-opcode outputs.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        t1,
  input  logic        t2,
  input  logic [15:0] ir,
  input  logic [15:0] pc,
  input  logic [2:0]  rsel,
  output logic [15:0] rdata,
  output logic        jp,
  output logic [15:0] pcnew,
  output logic        zf,
  output logic        cf,
  output logic        ill,
  output logic        busy
);

  localparam int unsigned W  = 16;
  localparam int unsigned NR = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXE  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_MOVI = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_BC   = 4'hB;

  logic [1:0]   state, state_n;
  logic [W-1:0] ir_q, pc_q;
  logic [W-1:0] regs [NR];

  logic [3:0]   op;
  logic [2:0]   rd, rs;
  logic [W-1:0] a, b, res, target;
  logic [W:0]   sum;
  logic         exec_en, wr_en, flag_en, cf_n, br_take, ill_set;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:9];
  assign rs     = ir_q[8:6];
  assign a      = regs[rd];
  assign b      = regs[rs];
  assign sum    = (W+1)'(a) + (W+1)'(b);
  assign target = pc_q + {{3{ir_q[11]}}, ir_q[11:0], 1'b0};

  assign rdata   = regs[rsel];
  assign busy    = (state == S_EXE);
  assign exec_en = (state == S_EXE) && t2 && !t1;

  // Next state: t1 always restarts, t2 only completes an instruction in flight
  always_comb begin
    state_n = state;
    if (t1)
      state_n = S_EXE;
    else if (t2 && (state == S_EXE))
      state_n = S_DONE;
  end

  // Operation decode on the latched instruction
  always_comb begin
    res     = a;
    wr_en   = 1'b0;
    flag_en = 1'b0;
    cf_n    = 1'b0;
    br_take = 1'b0;
    ill_set = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_ADD:  begin res = sum[W-1:0];        cf_n = sum[W];   wr_en = 1'b1; flag_en = 1'b1; end
      OP_SUB:  begin res = a - b;             cf_n = (a < b);  wr_en = 1'b1; flag_en = 1'b1; end
      OP_AND:  begin res = a & b;                              wr_en = 1'b1; flag_en = 1'b1; end
      OP_OR:   begin res = a | b;                              wr_en = 1'b1; flag_en = 1'b1; end
      OP_XOR:  begin res = a ^ b;                              wr_en = 1'b1; flag_en = 1'b1; end
      OP_SHL:  begin res = {a[W-2:0], 1'b0};  cf_n = a[W-1];   wr_en = 1'b1; flag_en = 1'b1; end
      OP_SHR:  begin res = {1'b0, a[W-1:1]};  cf_n = a[0];     wr_en = 1'b1; flag_en = 1'b1; end
      OP_MOVI: begin res = {8'h00, ir_q[7:0]};                 wr_en = 1'b1; end
      OP_JMP:  br_take = 1'b1;
      OP_BZ:   br_take = zf;
      OP_BC:   br_take = cf;
      default: ill_set = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir_q  <= '0;
      pc_q  <= '0;
      jp    <= 1'b0;
      pcnew <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
      ill   <= 1'b0;
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      if (t1) begin
        ir_q <= ir;
        pc_q <= pc;
        jp   <= 1'b0;
      end else if (exec_en) begin
        if (wr_en)   regs[rd] <= res;
        if (flag_en) begin
          zf <= (res == '0);
          cf <= cf_n;
        end
        jp <= br_take;
        if (br_take) pcnew <= target;
        if (ill_set) ill <= 1'b1;
      end
    end
  end

endmodule
